sat_accumulator: RTL and testbench
==================================

# sat_accumulator

Sequential stage directly downstream of the 8-bit signed `adder`. Accepts a stream of two's-complement 8-bit samples over a valid/ready handshake, folds each into a running sum through an internal `adder` instance (ports `a`, `b`, `s`, `overflow`), and saturates on overflow. After `COUNT` accepted samples it presents the frame sum plus saturation statistics on a held output handshake, then starts the next frame from zero.

## Interface
- `COUNT`, 4, samples per frame; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` carries a sample.
- `in_ready`  out  1  block can accept a sample; equals (state == ACCUM).
- `in_data`  in  8  signed sample.
- `out_valid`  out  1  frame result is available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  8  signed saturated frame sum.
- `out_sat`  out  1  at least one saturation occurred in the frame.
- `out_sat_cnt`  out  8  number of saturating additions in the frame; sticks at 255.

## Operation
- Internal registers: `acc[7:0]`, `cnt[7:0]`, `sat_cnt[7:0]`, `state`.
- Datapath: `adder` instance with `a = acc` and `b = in_data`. The instance produces `s` and `overflow`, where overflow = (a[7] == b[7]) && (s[7] != a[7]).
- Saturated next value: if `overflow` is 0, the value is `s`. If `overflow` is 1, the value is 8'h7F when `acc[7]` = 0, and 8'h80 when `acc[7]` = 1.
- FSM state ACCUM (reset state):
  - `in_ready` = 1.
  - On `in_valid && in_ready`, `acc` takes the saturated value.
  - On the same acceptance, `sat_cnt` increments if `overflow` is set, clamped at 255.
  - `cnt` increments on each acceptance.
- Frame completion: a sample accepted while `cnt == COUNT-1` completes the frame. On that edge:
  - `out_sum` loads the saturated value, including the final sample.
  - `out_sat_cnt` loads `sat_cnt` plus that sample's overflow, clamped at 255.
  - `out_sat` = (loaded count != 0).
  - `out_valid` goes to 1 and `state` goes to HOLD.
  - `acc`, `cnt` and `sat_cnt` clear to 0.
- FSM state HOLD:
  - `in_ready` = 0; `in_valid` is ignored and no sample is consumed.
  - `out_sum`, `out_sat` and `out_sat_cnt` are held stable.
  - On `out_valid && out_ready`, `out_valid` goes to 0 and `state` returns to ACCUM.
- `out_ready` has no effect while `out_valid` = 0.
- `COUNT` = 1: every accepted sample completes a frame; `out_sum` = `in_data`, since 0 + x never overflows.
- Reset values: `state` = ACCUM; `acc`, `cnt`, `sat_cnt` = 0; `in_ready` = 1; `out_valid` = 0; `out_sum` = 8'h00; `out_sat` = 0; `out_sat_cnt` = 0.
- Reset asserted mid-frame or in HOLD discards the partial sum and any pending result immediately, without waiting for a clock edge.

## Timing
- One sample can be accepted per cycle while in ACCUM.
- Latency: `out_valid` rises on the same edge that accepts the `COUNT`-th sample. The result is visible in the cycle after acceptance.
- `in_ready` falls on that same edge. It rises again on the edge after the output handshake, so the first sample of the next frame is accepted one cycle later at the earliest.
- Best-case throughput: one frame per `COUNT`+1 cycles, with `out_ready` tied high.
- Simultaneous `in_valid` and a completed output handshake in the same HOLD cycle: the sample is not accepted. The source must hold it until `in_ready` = 1.
- `cnt` never exceeds `COUNT-1`, and `acc` never wraps.
- Reset deassertion: the first edge with `rst` = 0 may accept a sample.

## Test plan
All scenarios use `COUNT` = 4.
- Plain sum: samples 10, 20, 30, 40 back-to-back with `out_ready` = 1 → `out_sum` = 100 (0x64), `out_sat` = 0, `out_sat_cnt` = 0. `out_valid` is high for exactly 1 cycle and `in_ready` is low for exactly 1 cycle.
- Positive saturation: samples 100, 50, -10, 5.
  - 100 + 50 saturates to 127; the sum then goes to 117, then 122.
  - Result: `out_sum` = 122 (0x7A), `out_sat` = 1, `out_sat_cnt` = 1.
- Negative saturation: samples -60, -70, -128, 1.
  - The sum goes to -128, then -128 again (second saturation), then -127.
  - Result: `out_sum` = 0x81, `out_sat_cnt` = 2.
- Backpressure: after frame 10, 20, 30, 40, hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 with `in_data` = 0x7F.
  - During the hold: `out_sum` stays 0x64 and `in_ready` stays 0.
  - On the `out_ready` pulse, the handshake occurs.
  - The next frame of 4 × 0x7F yields `out_sum` = 0x7F and `out_sat_cnt` = 3.
- Reset mid-frame: accept 50 and 50, then pulse `rst` between clock edges.
  - All outputs return to their reset values immediately.
  - The following samples 1, 1, 1, 1 → `out_sum` = 4, `out_sat` = 0.
- Gapped input: samples 127, 1, -1, 0 with `in_valid` low for 2 cycles between samples → `out_sum` = 126 (0x7E), `out_sat_cnt` = 1. No sample is accepted while `in_valid` = 0.

Source files
------------

// File: rtl/sat_accumulator.sv
// Frame accumulator for signed 8-bit samples: sums COUNT samples with
// saturation and reports the frame sum plus the number of saturating additions.

module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       overflow
);
  assign s        = a + b;
  assign overflow = (a[7] == b[7]) && (s[7] != a[7]);
endmodule

module sat_accumulator #(
  parameter int unsigned COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_sat,
  output logic [7:0] out_sat_cnt
);
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  // Handshake contract: a transfer happens on a rising edge where valid and
  // ready are both high; the producer holds valid and data until that edge.

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sat_cnt_q, sat_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_sum_q, out_sum_d;
  logic       out_sat_q, out_sat_d;
  logic [7:0] out_sat_cnt_q, out_sat_cnt_d;

  logic [7:0] add_s;
  logic       add_ovf;
  logic [7:0] sat_val;
  logic [7:0] sat_inc;
  logic       accept;

  adder u_adder (
    .a        (acc_q),
    .b        (in_data),
    .s        (add_s),
    .overflow (add_ovf)
  );

  always_comb begin
    accept  = in_valid && (state_q == ACCUM);
    // On overflow both operands share acc's sign, so acc[7] picks the rail.
    sat_val = add_ovf ? (acc_q[7] ? 8'h80 : 8'h7F) : add_s;
    sat_inc = (add_ovf && (sat_cnt_q != 8'hFF)) ? sat_cnt_q + 8'd1 : sat_cnt_q;

    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sat_cnt_d     = sat_cnt_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_sat_d     = out_sat_q;
    out_sat_cnt_d = out_sat_cnt_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == LAST) begin
            out_sum_d     = sat_val;
            out_sat_cnt_d = sat_inc;
            out_sat_d     = (sat_inc != 8'd0);
            out_valid_d   = 1'b1;
            state_d       = HOLD;
            acc_d         = 8'd0;
            cnt_d         = 8'd0;
            sat_cnt_d     = 8'd0;
          end else begin
            acc_d     = sat_val;
            cnt_d     = cnt_q + 8'd1;
            sat_cnt_d = sat_inc;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      acc_q         <= 8'd0;
      cnt_q         <= 8'd0;
      sat_cnt_q     <= 8'd0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= 8'd0;
      out_sat_q     <= 1'b0;
      out_sat_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sat_cnt_q     <= sat_cnt_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_sat_q     <= out_sat_d;
      out_sat_cnt_q <= out_sat_cnt_d;
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_sat     = out_sat_q;
  assign out_sat_cnt = out_sat_cnt_q;
endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: expected frame results are queued by the
// stimulus thread and popped by a monitor at each output handshake.

module tb_sat_accumulator;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_sat;
  logic [7:0] out_sat_cnt;

  logic [16:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  sat_accumulator #(.COUNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_sat     (out_sat),
    .out_sat_cnt (out_sat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present one sample and wait (bounded) until it is accepted
  task automatic send(input logic [7:0] d, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("gap_no_output", {16'd0, out_valid}, 17'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      k++;
    end
    chk("send_timeout", 17'd1, 17'd0);
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] sum, input logic sat, input logic [7:0] cnt);
    exp_q.push_back({sum, sat, cnt});
  endtask

  // scoreboard monitor: compare at each output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {out_sum, out_sat, out_sat_cnt}, 17'h1FFFF);
      end else begin
        chk("frame_result", {out_sum, out_sat, out_sat_cnt}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready",    {16'd0, in_ready},    17'd1);
    chk("rst_out_valid",   {16'd0, out_valid},   17'd0);
    chk("rst_out_sum",     {9'd0, out_sum},      17'd0);
    chk("rst_out_sat",     {16'd0, out_sat},     17'd0);
    chk("rst_out_sat_cnt", {9'd0, out_sat_cnt},  17'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // plain sum, one-cycle result and one-cycle in_ready gap
    expect_frame(8'h64, 1'b0, 8'd0);
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0); send(8'd40, 0);
    chk("plain_valid_hi", {16'd0, out_valid}, 17'd1);
    chk("plain_ready_lo", {16'd0, in_ready},  17'd0);
    @(posedge clk);
    #1;
    chk("plain_valid_lo", {16'd0, out_valid}, 17'd0);
    chk("plain_ready_hi", {16'd0, in_ready},  17'd1);

    // positive saturation: 100+50 -> 127, 117, 122
    expect_frame(8'h7A, 1'b1, 8'd1);
    send(8'd100, 0); send(8'd50, 0); send(8'hF6, 0); send(8'd5, 0);

    // negative saturation: -130 -> -128, -256 -> -128, -127
    expect_frame(8'h81, 1'b1, 8'd2);
    send(8'hC4, 0); send(8'hBA, 0); send(8'h80, 0); send(8'd1, 0);
    @(posedge clk);
    #1;

    // backpressure with in_valid held high during HOLD
    out_ready = 1'b0;
    expect_frame(8'h64, 1'b0, 8'd0);
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0); send(8'd40, 0);
    in_valid = 1'b1;
    in_data  = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum_held",  {9'd0, out_sum},     17'h64);
      chk("bp_ready_lo",  {16'd0, in_ready},   17'd0);
      chk("bp_valid_hi",  {16'd0, out_valid},  17'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake_done", {16'd0, out_valid}, 17'd0);
    expect_frame(8'h7F, 1'b1, 8'd3);
    send(8'h7F, 0); send(8'h7F, 0); send(8'h7F, 0); send(8'h7F, 0);
    @(posedge clk);
    #1;

    // asynchronous reset mid-frame
    send(8'd50, 0); send(8'd50, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",    {16'd0, in_ready},   17'd1);
    chk("mid_rst_out_valid",   {16'd0, out_valid},  17'd0);
    chk("mid_rst_out_sum",     {9'd0, out_sum},     17'd0);
    chk("mid_rst_out_sat",     {16'd0, out_sat},    17'd0);
    chk("mid_rst_out_sat_cnt", {9'd0, out_sat_cnt}, 17'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_frame(8'h04, 1'b0, 8'd0);
    send(8'd1, 0); send(8'd1, 0); send(8'd1, 0); send(8'd1, 0);
    @(posedge clk);
    #1;

    // gapped input: 127, 1 (sat), -1, 0
    expect_frame(8'h7E, 1'b1, 8'd1);
    send(8'h7F, 2); send(8'd1, 2); send(8'hFF, 2); send(8'd0, 2);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
    end
    #1;
    chk("queue_drained", 17'(exp_q.size()), 17'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
